// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - machine-mode trap entry / MRET sequencer over a single CSR write port
// Optional mtval write enabled by defining TRAP_TVAL_EN.
module trap_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            TRAP_REQ,
  input  logic [XLEN-1:0] TRAP_CAUSE,
  input  logic [XLEN-1:0] TRAP_EPC,
  input  logic [XLEN-1:0] TRAP_TVAL,
  input  logic            RET_REQ,
  input  logic [XLEN-1:0] MTVEC,
  input  logic [XLEN-1:0] MEPC_IN,
  input  logic [XLEN-1:0] MSTATUS_IN,
  output logic            CSR_WEN,
  output logic [11:0]     CSR_ADDR,
  output logic [XLEN-1:0] CSR_WDATA,
  output logic            STALL,
  output logic            FE_PC_MUX,
  output logic [XLEN-1:0] FE_TARGET,
  output logic            FLUSH,
  output logic [1:0]      PRIV_OUT,
  output logic            BUSY
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_EPC    = 3'd1,
    W_CAUSE  = 3'd2,
    W_TVAL   = 3'd3,
    W_STATUS = 3'd4,
    R_STATUS = 3'd5,
    REDIRECT = 3'd6
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:2] epc_q;
  logic [1:0]      priv_q;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] trap_status;
  logic [XLEN-1:0] ret_status;

`ifdef TRAP_TVAL_EN
  logic [XLEN-1:0] tval_q;
  logic            unused_epc_lsb;
  assign unused_epc_lsb = ^TRAP_EPC[1:0];
`else
  logic            unused_inputs;
  assign unused_inputs = ^{TRAP_TVAL, TRAP_EPC[1:0]};
`endif

  // Vectored mode only offsets interrupts; exceptions always land on the base.
  always_comb begin
    trap_base = {MTVEC[XLEN-1:2], 2'b00};
    if (MTVEC[1:0] == 2'b01 && TRAP_CAUSE[XLEN-1])
      trap_target = trap_base + {{(XLEN-8){1'b0}}, TRAP_CAUSE[5:0], 2'b00};
    else
      trap_target = trap_base;
  end

  always_comb begin
    trap_status        = MSTATUS_IN;
    trap_status[7]     = MSTATUS_IN[3];
    trap_status[3]     = 1'b0;
    trap_status[12:11] = priv_q;
    ret_status         = MSTATUS_IN;
    ret_status[3]      = MSTATUS_IN[7];
    ret_status[7]      = 1'b1;
    ret_status[12:11]  = 2'b00;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      cause_q  <= '0;
      epc_q    <= '0;
      priv_q   <= 2'b00;
      target_q <= '0;
      PRIV_OUT <= 2'b11;
`ifdef TRAP_TVAL_EN
      tval_q   <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (TRAP_REQ) begin
          cause_q  <= TRAP_CAUSE;
          epc_q    <= TRAP_EPC[XLEN-1:2];
          priv_q   <= PRIV_OUT;
          target_q <= trap_target;
`ifdef TRAP_TVAL_EN
          tval_q   <= TRAP_TVAL;
`endif
        end else if (RET_REQ) begin
          target_q <= MEPC_IN;
        end
      end
      if (state == W_STATUS)
        PRIV_OUT <= 2'b11;
      else if (state == R_STATUS)
        PRIV_OUT <= MSTATUS_IN[12:11];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (TRAP_REQ)
          state_nxt = W_EPC;
        else if (RET_REQ)
          state_nxt = R_STATUS;
      end
      W_EPC:    state_nxt = W_CAUSE;
`ifdef TRAP_TVAL_EN
      W_CAUSE:  state_nxt = W_TVAL;
      W_TVAL:   state_nxt = W_STATUS;
`else
      W_CAUSE:  state_nxt = W_STATUS;
`endif
      W_STATUS: state_nxt = REDIRECT;
      R_STATUS: state_nxt = REDIRECT;
      REDIRECT: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Strobes decode from the registered state; only STALL looks at the live requests.
  always_comb begin
    CSR_WEN   = 1'b0;
    CSR_ADDR  = 12'h000;
    CSR_WDATA = '0;
    FE_PC_MUX = 1'b0;
    FLUSH     = 1'b0;
    FE_TARGET = '0;
    BUSY      = (state != IDLE);
    STALL     = BUSY || ((state == IDLE) && (TRAP_REQ || RET_REQ));
    case (state)
      W_EPC: begin
        CSR_WEN   = 1'b1;
        CSR_ADDR  = 12'h341;
        CSR_WDATA = {epc_q, 2'b00};
      end
      W_CAUSE: begin
        CSR_WEN   = 1'b1;
        CSR_ADDR  = 12'h342;
        CSR_WDATA = cause_q;
      end
`ifdef TRAP_TVAL_EN
      W_TVAL: begin
        CSR_WEN   = 1'b1;
        CSR_ADDR  = 12'h343;
        CSR_WDATA = tval_q;
      end
`endif
      W_STATUS: begin
        CSR_WEN   = 1'b1;
        CSR_ADDR  = 12'h300;
        CSR_WDATA = trap_status;
      end
      R_STATUS: begin
        CSR_WEN   = 1'b1;
        CSR_ADDR  = 12'h300;
        CSR_WDATA = ret_status;
      end
      REDIRECT: begin
        FE_PC_MUX = 1'b1;
        FLUSH     = 1'b1;
        FE_TARGET = target_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Multi-cycle controller that sequences machine-mode trap entry and MRET return after the writeback stage flags them. It serialises the CSR updates (mepc, mcause, optional mtval, mstatus) over a single CSR write port, then redirects fetch and tracks the current privilege level. The pipeline is held while a sequence is in flight.

## Interface
Parameters:
- XLEN, 64, datapath width

Ports:
- CLK  in  1  clock
- RESET_N  in  1  reset; asynchronous and active-low
- TRAP_REQ  in  1  trap detected at writeback (one valid instruction)
- TRAP_CAUSE  in  64  cause; bit 63 = interrupt
- TRAP_EPC  in  64  PC of trapping instruction
- TRAP_TVAL  in  64  faulting value
- RET_REQ  in  1  MRET retiring at writeback
- MTVEC  in  64  current mtvec
- MEPC_IN  in  64  current mepc
- MSTATUS_IN  in  64  current mstatus (combinational CSR read)
- CSR_WEN  out  1  CSR write strobe
- CSR_ADDR  out  12  CSR address
- CSR_WDATA  out  64  CSR write data
- STALL  out  1  hold writeback and upstream stages
- FE_PC_MUX  out  1  fetch redirect strobe
- FE_TARGET  out  64  redirect address
- FLUSH  out  1  squash in-flight instructions
- PRIV_OUT  out  2  current privilege
- BUSY  out  1  state != IDLE

## Operation
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, R_STATUS, REDIRECT.
- IDLE, TRAP_REQ=1: capture TRAP_CAUSE/EPC/TVAL, PRIV_OUT, and the computed target; go to W_EPC. TRAP_REQ wins over a simultaneous RET_REQ.
- IDLE, RET_REQ=1 (no TRAP_REQ): capture MEPC_IN as target; go to R_STATUS.
- W_EPC: CSR_WEN=1, ADDR=0x341, WDATA={EPC[63:2],2'b00}.
- W_CAUSE: ADDR=0x342, WDATA=captured cause.
- W_TVAL: ADDR=0x343, WDATA=captured tval. Present only when TRAP_TVAL_EN is defined.
- W_STATUS: ADDR=0x300, WDATA=MSTATUS_IN with bit7 (MPIE)←bit3 (MIE), bit3←0, bits[12:11] (MPP)←captured privilege. PRIV_OUT←2'b11 at the end of the cycle.
- R_STATUS: ADDR=0x300, WDATA=MSTATUS_IN with bit3←bit7, bit7←1, [12:11]←2'b00. PRIV_OUT←old MPP.
- REDIRECT: FE_PC_MUX=1, FLUSH=1, FE_TARGET=captured target, CSR_WEN=0; go to IDLE.
- Target computation: base={MTVEC[63:2],2'b00}.
  - MTVEC[1:0]=01 and cause[63]=1: target = base + (cause[5:0]<<2), modulo 2^64.
  - Otherwise: target = base.
- Requests arriving while not in IDLE are ignored. The writeback stage holds its instruction because STALL is high.

## Timing
- Reset values:
  - state=IDLE, PRIV_OUT=2'b11, all captured registers 0.
  - CSR_WEN=0, CSR_ADDR=0, CSR_WDATA=0, STALL=0, FE_PC_MUX=0, FE_TARGET=0, FLUSH=0, BUSY=0.
- Reset asserted mid-sequence aborts immediately to the reset values. A partial CSR update is not rolled back.
- CSR_WEN, CSR_ADDR and CSR_WDATA are decoded from the registered state; the write commits on the edge that ends each state.
- STALL = (TRAP_REQ | RET_REQ) in IDLE (combinational) | BUSY.
- Trap accepted on edge N:
  - With TRAP_TVAL_EN: W_EPC N+1, W_CAUSE N+2, W_TVAL N+3, W_STATUS N+4, REDIRECT N+5, IDLE N+6.
  - Without TRAP_TVAL_EN: REDIRECT is at N+4.
- MRET accepted on edge N: R_STATUS N+1, REDIRECT N+2, IDLE N+3.
- FE_PC_MUX and FLUSH are exactly one-cycle pulses.
- A new request is accepted in the first IDLE cycle after REDIRECT (back-to-back allowed).

## Configuration
- TRAP_TVAL_EN defined: the W_TVAL state exists and mtval (0x343) is written with the captured TRAP_TVAL.
- TRAP_TVAL_EN not defined: W_CAUSE goes directly to W_STATUS, mtval is never written, TRAP_TVAL is unused, and trap latency is one cycle shorter.

## Test plan
- Reset: RESET_N low, then high → PRIV_OUT=3, all strobes 0, BUSY=0.
- ECALL from U-mode (PRIV_OUT forced 0 via prior MRET, cause=8, EPC=0x8000_0104, MTVEC=0x8000_0000, MSTATUS_IN=0x8):
  - CSR writes in order 0x341=0x8000_0104, 0x342=8, (0x343 with TRAP_TVAL_EN), 0x300=0x80.
  - Then FE_PC_MUX with FE_TARGET=0x8000_0000, PRIV_OUT=3.
- Vectored interrupt (MTVEC=0x8000_0101, cause=0x8000_0000_0000_000B) → FE_TARGET=0x8000_012C.
- MRET (MEPC_IN=0x8000_0200, MSTATUS_IN=0x80) → 0x300 written 0x88, PRIV_OUT=0, redirect to 0x8000_0200 at N+2.
- Simultaneous TRAP_REQ and RET_REQ → trap sequence only; RET_REQ reasserted during BUSY is ignored.
- RESET_N dropped in W_CAUSE → next cycle IDLE, CSR_WEN=0, no FE_PC_MUX pulse, PRIV_OUT=3.
